// File: rtl/cpu_core.sv
// cpu_core: bus sequencer for the 8-bit accumulator machine (4-cycle loop).
// Define CPU_CORE_HALT_EN to turn opcode 110 into HLT and add the halted port.
module cpu_core #(
  parameter logic [4:0] RESET_PC = 5'd0,
  parameter logic [4:0] OUT_ADDR = 5'd31
) (
  input  logic       tclk,
  input  logic       rst_n,
  output logic [4:0] a_bus,
  inout  wire  [7:0] d_bus,
  output logic [7:0] instruction,
  output logic [1:0] state,
  output logic [7:0] acc,
  output logic       zero
`ifdef CPU_CORE_HALT_EN
  ,
  output logic       halted
`endif
);

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    DECODE = 2'b01,
    EXEC_A = 2'b10,
    EXEC_B = 2'b11
  } cyc_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_ST   = 3'b100;
  localparam logic [2:0] OP_LD   = 3'b101;
  localparam logic [2:0] OP_JPNZ = 3'b111;
`ifdef CPU_CORE_HALT_EN
  localparam logic [2:0] OP_HLT  = 3'b110;
`endif

  cyc_t       cyc;
  logic [4:0] pc;
  logic [7:0] ir;
  logic [2:0] op;
  logic       drive;
  logic       frozen;

`ifdef CPU_CORE_HALT_EN
  logic halt_q;
  assign frozen = halt_q;
  assign halted = halt_q;
`else
  assign frozen = 1'b0;
`endif

  assign op          = ir[7:5];
  assign instruction = ir;
  assign state       = cyc;
  assign zero        = (acc == 8'h00);
  assign a_bus       = (cyc == FETCH) ? pc : ir[4:0];

  // Store data only in the two execute cycles; a pending reset kills it.
  assign drive = rst_n && (op == OP_ST) && cyc[1];
  assign d_bus = drive ? acc : 8'hzz;

  always_ff @(posedge tclk) begin
    if (!rst_n) begin
      cyc <= FETCH;
      pc  <= RESET_PC;
      ir  <= 8'h00;
      acc <= 8'h00;
`ifdef CPU_CORE_HALT_EN
      halt_q <= 1'b0;
`endif
    end else if (!frozen) begin
      unique case (cyc)
        FETCH: begin
          ir  <= d_bus;
          pc  <= pc + 5'd1;
          cyc <= DECODE;
        end
        DECODE: cyc <= EXEC_A;
        EXEC_A: cyc <= EXEC_B;
        EXEC_B: begin
          cyc <= FETCH;
          case (op)
            OP_ADD:  acc <= acc + d_bus;
            OP_NAND: acc <= ~(acc & d_bus);
            OP_LD:   acc <= d_bus;
            OP_JPNZ: if (acc != 8'h00) pc <= ir[4:0];
`ifdef CPU_CORE_HALT_EN
            OP_HLT: begin
              cyc    <= EXEC_B;
              halt_q <= 1'b1;
            end
`endif
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: directed and random programs run against an ISA-level model.
// Memory responder lives here; the model keeps its own copy of memory.
module tb_cpu_core;

  logic       tclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] a_bus;
  wire  [7:0] d_bus;
  logic [7:0] instruction;
  logic [1:0] state;
  logic [7:0] acc;
  logic       zero;
`ifdef CPU_CORE_HALT_EN
  logic       halted;
`endif

  always #5 tclk = ~tclk;

  cpu_core dut (
    .tclk(tclk),
    .rst_n(rst_n),
    .a_bus(a_bus),
    .d_bus(d_bus),
    .instruction(instruction),
    .state(state),
    .acc(acc),
    .zero(zero)
`ifdef CPU_CORE_HALT_EN
    ,
    .halted(halted)
`endif
  );

  logic [7:0] ram [32];
  logic       cpu_st;

  assign cpu_st = (instruction[7:5] == 3'b100) && state[1];
  assign d_bus  = cpu_st ? 8'hzz : ram[a_bus];

  always @(posedge tclk)
    if (rst_n && cpu_st && state == 2'b11)
      ram[a_bus] = d_bus;

  int npass = 0;
  int ntot  = 0;

  logic [7:0] mm [32];
  logic [4:0] mpc;
  logic [7:0] macc;
  logic [7:0] mir;
  bit         mhalt;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic put(input int a, input logic [7:0] v);
    ram[a] = v;
    mm[a]  = v;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) put(i, 8'h20);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge tclk);
    rst_n = 1'b1;
    mpc   = 5'd0;
    macc  = 8'h00;
    mir   = 8'h00;
    mhalt = 1'b0;
    chk("rst_state", state, 2'b00);
    chk("rst_abus", a_bus, 5'd0);
    chk("rst_acc", acc, 8'h00);
    chk("rst_ir", instruction, 8'h00);
    chk("rst_zero", zero, 1'b1);
`ifdef CPU_CORE_HALT_EN
    chk("rst_halted", halted, 1'b0);
`endif
  endtask

  // One architectural instruction; entered and left at a FETCH negedge.
  task automatic step();
    logic [7:0] iw;
    logic [4:0] ad;
    logic [2:0] op;
    if (mhalt) begin
      @(negedge tclk);
      chk("halt_state", state, 2'b11);
      chk("halt_abus", a_bus, mir[4:0]);
      chk("halt_acc", acc, macc);
      chk("halt_ir", instruction, mir);
      chk("halt_dbus", d_bus, mm[mir[4:0]]);
`ifdef CPU_CORE_HALT_EN
      chk("halt_flag", halted, 1'b1);
`endif
      return;
    end
    iw = mm[mpc];
    ad = iw[4:0];
    op = iw[7:5];
    chk("f_state", state, 2'b00);
    chk("f_abus", a_bus, mpc);
    chk("f_dbus", d_bus, iw);
`ifdef CPU_CORE_HALT_EN
    chk("f_halted", halted, 1'b0);
`endif
    @(negedge tclk);
    mpc = mpc + 5'd1;
    mir = iw;
    chk("d_state", state, 2'b01);
    chk("d_abus", a_bus, ad);
    chk("d_ir", instruction, iw);
    for (int k = 2; k < 4; k++) begin
      @(negedge tclk);
      chk("x_state", state, k);
      chk("x_abus", a_bus, ad);
      chk("x_dbus", d_bus, (op == 3'b100) ? macc : mm[ad]);
    end
    case (op)
      3'b000: macc = macc + mm[ad];
      3'b010: macc = ~(macc & mm[ad]);
      3'b100: mm[ad] = macc;
      3'b101: macc = mm[ad];
      3'b111: if (macc != 8'h00) mpc = ad;
`ifdef CPU_CORE_HALT_EN
      3'b110: mhalt = 1'b1;
`endif
      default: ;
    endcase
    @(negedge tclk);
    chk("acc", acc, macc);
    chk("zero", zero, macc == 8'h00);
    if (op == 3'b100) chk("st_mem", ram[ad], mm[ad]);
    if (mhalt) chk("hlt_state", state, 2'b11);
  endtask

  initial begin
    // Reset and first fetch of LD 5
    clear_mem();
    put(0, 8'hA5);
    put(5, 8'h42);
    do_reset();
    step();
    chk("ld5_acc", acc, 8'h42);
    chk("pc_after", a_bus, 5'd1);

    // LD/ADD, NAND to zero, ST to port, JPNZ taken/not taken, wrap
    clear_mem();
    put(0, 8'hB4);  put(1, 8'h15);  put(2, 8'hB6);  put(3, 8'h56);
    put(4, 8'hB7);  put(5, 8'h9F);  put(6, 8'hE9);  put(9, 8'hB8);
    put(10, 8'hE3); put(11, 8'hB9); put(12, 8'hFE);
    put(20, 8'hF0); put(21, 8'h25); put(22, 8'hFF); put(23, 8'h3C);
    put(24, 8'h00); put(25, 8'h01);
    do_reset();
    step();
    chk("ld_f0", acc, 8'hF0);
    step();
    chk("add_wrap", acc, 8'h15);
    chk("add_zero", zero, 1'b0);
    step();
    step();
    chk("nand_acc", acc, 8'h00);
    chk("nand_zero", zero, 1'b1);
    step();
    step();
    chk("st_port", ram[31], 8'h3C);
    step();
    chk("jpnz_taken", a_bus, 5'd9);
    step();
    step();
    chk("jpnz_not", a_bus, 5'd11);
    repeat (4) step();
    chk("pc_wrap", a_bus, 5'd0);
    step();

    // Reset during EXEC_A of a store
    clear_mem();
    put(0, 8'hB7); put(1, 8'h9A); put(23, 8'h3C); put(26, 8'h77);
    do_reset();
    step();
    @(negedge tclk);
    @(negedge tclk);
    chk("ea_drive", d_bus, 8'h3C);
    rst_n = 1'b0;
    @(negedge tclk);
    rst_n = 1'b1;
    chk("ab_state", state, 2'b00);
    chk("ab_abus", a_bus, 5'd0);
    chk("ab_acc", acc, 8'h00);
    chk("ab_dbus", d_bus, 8'hB7);
    chk("ab_mem", ram[26], 8'h77);
    mpc = 5'd0; macc = 8'h00; mir = 8'h00; mhalt = 1'b0;
    step();

`ifdef CPU_CORE_HALT_EN
    clear_mem();
    put(0, 8'hB7); put(1, 8'hC9); put(23, 8'h3C);
    do_reset();
    step();
    step();
    chk("hlt_flag", halted, 1'b1);
    repeat (10) step();
    chk("hlt_abus", a_bus, 5'd9);
`endif

    // Random programs
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 32; i++) put(i, 8'($urandom));
      do_reset();
      repeat (50) step();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
